hpi_responder: RTL and testbench

Synthesizable responder for the 16-bit EZ-OTG host-port interface (HPI) that the NIOS software drives through its `otg_hpi_*` PIO exports. It decodes the four HPI registers (DATA, MAILBOX, ADDRESS, STATUS) and backs them with a word RAM and two mailboxes. This lets the keyboard path be run against an in-fabric emulated USB controller instead of the external chip. A local fabric port lets an emulated keyboard source write report words and exchange mailbox messages.

---
 rtl/hpi_responder_if.sv | 21 ++
 rtl/hpi_responder.sv | 218 +++++++++++++++++++++
 tb/tb_hpi_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_responder_if.sv
// HPI bus between the NIOS host-port initiator and the emulated EZ-OTG responder.
// The strobes and soft reset are asynchronous to the responder clock.
interface hpi_responder_if;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;
    logic        hpi_cs_n;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic        hpi_reset_n;

    modport master (
        output hpi_addr, hpi_data_in, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n,
        input  hpi_data_out
    );

    modport slave (
        input  hpi_addr, hpi_data_in, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n,
        output hpi_data_out
    );
endinterface

// File: rtl/hpi_responder.sv
// EZ-OTG host-port responder: DATA/MAILBOX/ADDRESS/STATUS registers backed by a
// word RAM, with a local fabric port for an emulated keyboard source.
module hpi_responder #(
    parameter int MEM_AW = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    hpi_responder_if.slave    hpi,
    input  logic [MEM_AW-1:0] loc_addr,
    input  logic              loc_we,
    input  logic [15:0]       loc_wdata,
    output logic [15:0]       loc_rdata,
    output logic              mbx_in_valid,
    output logic [15:0]       mbx_in_data,
    input  logic              mbx_in_ack,
    input  logic              mbx_out_we,
    input  logic [15:0]       mbx_out_wdata,
    output logic              mbx_out_full
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WR_ACT = 2'd1,
        S_RD_ACT = 2'd2
    } state_t;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_MAILBOX = 2'd1;
    localparam logic [1:0] REG_ADDRESS = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic [1:0]        r_cs_sync;
    logic [1:0]        r_rd_sync;
    logic [1:0]        r_wr_sync;
    logic [1:0]        r_rst_sync;
    logic              w_cs_n;
    logic              w_r_n;
    logic              w_w_n;
    logic              w_hpi_rst;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_rd_enter;
    logic              w_rd_exit;
    logic              w_wr_commit;

    logic [15:0]       r_ptr;
    logic [MEM_AW-1:0] w_ptr_idx;
    logic [15:0]       r_data_out;
    logic [1:0]        r_rd_addr;
    logic              r_rd_first;
    logic              r_mbx_in_valid;
    logic [15:0]       r_mbx_in_data;
    logic [15:0]       r_mbx_out_data;
    logic              r_mbx_out_full;
    logic [15:0]       w_status;
    logic              w_hpi_mem_we;
    logic              w_data_advance;

    logic [15:0]       r_mem [2**MEM_AW];
    logic [15:0]       r_ram_q;
    logic [15:0]       r_loc_rdata;

    // Strobes idle high, so the synchronizers reset to the inactive level.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cs_sync  <= 2'b11;
            r_rd_sync  <= 2'b11;
            r_wr_sync  <= 2'b11;
            r_rst_sync <= 2'b11;
        end else begin
            r_cs_sync  <= {r_cs_sync[0],  hpi.hpi_cs_n};
            r_rd_sync  <= {r_rd_sync[0],  hpi.hpi_r_n};
            r_wr_sync  <= {r_wr_sync[0],  hpi.hpi_w_n};
            r_rst_sync <= {r_rst_sync[0], hpi.hpi_reset_n};
        end
    end

    assign w_cs_n    = r_cs_sync[1];
    assign w_r_n     = r_rd_sync[1];
    assign w_w_n     = r_wr_sync[1];
    assign w_hpi_rst = Reset || !r_rst_sync[1];

    always_ff @(posedge Clk) begin
        if (w_hpi_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // Both strobes low at once is illegal and deliberately ignored.
                if (!w_cs_n && !w_w_n && w_r_n) begin
                    w_next_state = S_WR_ACT;
                end else if (!w_cs_n && !w_r_n && w_w_n) begin
                    w_next_state = S_RD_ACT;
                end
            end
            S_WR_ACT: begin
                if (w_w_n || w_cs_n) begin
                    w_next_state = S_IDLE;
                end
            end
            S_RD_ACT: begin
                if (w_r_n || w_cs_n) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_enter  = 1'b0;
        w_rd_exit   = 1'b0;
        w_wr_commit = 1'b0;
        if (!w_hpi_rst) begin
            w_rd_enter  = (r_state == S_IDLE)   && (w_next_state == S_RD_ACT);
            w_rd_exit   = (r_state == S_RD_ACT) && (w_next_state == S_IDLE);
            w_wr_commit = (r_state == S_WR_ACT) && (w_next_state == S_IDLE);
        end
    end

    assign w_ptr_idx      = r_ptr[MEM_AW:1];
    assign w_status       = {7'b0, r_mbx_in_valid, 7'b0, r_mbx_out_full};
    assign w_hpi_mem_we   = w_wr_commit && (hpi.hpi_addr == REG_DATA);
    assign w_data_advance = w_hpi_mem_we || (w_rd_exit && (r_rd_addr == REG_DATA));

    always_ff @(posedge Clk) begin
        if (w_hpi_rst) begin
            r_ptr <= '0;
        end else if (w_wr_commit && (hpi.hpi_addr == REG_ADDRESS)) begin
            r_ptr <= hpi.hpi_data_in;
        end else if (w_data_advance) begin
            r_ptr <= r_ptr + 16'd2;
        end
    end

    // Register reads load on RD_ACT entry; DATA waits one more cycle for the RAM.
    always_ff @(posedge Clk) begin
        if (w_hpi_rst) begin
            r_data_out <= '0;
            r_rd_addr  <= REG_DATA;
            r_rd_first <= 1'b0;
        end else begin
            r_rd_first <= w_rd_enter;
            if (w_rd_enter) begin
                r_rd_addr <= hpi.hpi_addr;
                case (hpi.hpi_addr)
                    REG_MAILBOX: r_data_out <= r_mbx_out_data;
                    REG_ADDRESS: r_data_out <= r_ptr;
                    REG_STATUS:  r_data_out <= w_status;
                    default:     r_data_out <= r_data_out;
                endcase
            end else if (r_rd_first && (r_rd_addr == REG_DATA)) begin
                r_data_out <= r_ram_q;
            end
        end
    end

    // A host MAILBOX write outranks a same-cycle acknowledge.
    always_ff @(posedge Clk) begin
        if (w_hpi_rst) begin
            r_mbx_in_valid <= 1'b0;
            r_mbx_in_data  <= '0;
        end else if (w_wr_commit && (hpi.hpi_addr == REG_MAILBOX)) begin
            r_mbx_in_valid <= 1'b1;
            r_mbx_in_data  <= hpi.hpi_data_in;
        end else if (mbx_in_ack) begin
            r_mbx_in_valid <= 1'b0;
        end
    end

    // A fresh outbound load outranks the host read that drains the mailbox.
    always_ff @(posedge Clk) begin
        if (w_hpi_rst) begin
            r_mbx_out_data <= '0;
            r_mbx_out_full <= 1'b0;
        end else if (mbx_out_we) begin
            r_mbx_out_data <= mbx_out_wdata;
            r_mbx_out_full <= 1'b1;
        end else if (w_rd_exit && (r_rd_addr == REG_MAILBOX)) begin
            r_mbx_out_full <= 1'b0;
        end
    end

    // The HPI write is issued last so it wins a same-word collision with the local port.
    // NOTE: RAM contents are intentionally left unreset; only control state is cleared.
    always_ff @(posedge Clk) begin
        if (loc_we) begin
            r_mem[loc_addr] <= loc_wdata;
        end
        if (w_hpi_mem_we) begin
            r_mem[w_ptr_idx] <= hpi.hpi_data_in;
        end
        r_ram_q <= r_mem[w_ptr_idx];
    end

    // The local read register answers only to the system reset, not the HPI soft reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_loc_rdata <= '0;
        end else begin
            r_loc_rdata <= r_mem[loc_addr];
        end
    end

    assign hpi.hpi_data_out = r_data_out;
    assign loc_rdata        = r_loc_rdata;
    assign mbx_in_valid     = r_mbx_in_valid;
    assign mbx_in_data      = r_mbx_in_data;
    assign mbx_out_full     = r_mbx_out_full;
endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: transaction-level register/RAM/mailbox model,
// directed scenarios with literal expectations, then randomized host and local traffic.
module tb_hpi_responder;
    localparam int MEM_AW = 8;

    localparam logic [1:0] A_DATA    = 2'd0;
    localparam logic [1:0] A_MAILBOX = 2'd1;
    localparam logic [1:0] A_ADDRESS = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    localparam int SIDE_NONE   = 0;
    localparam int SIDE_LOC    = 1;
    localparam int SIDE_ACK    = 2;
    localparam int SIDE_MBXOUT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [MEM_AW-1:0] loc_addr = '0;
    logic              loc_we = 1'b0;
    logic [15:0]       loc_wdata = '0;
    logic [15:0]       loc_rdata;
    logic              mbx_in_valid;
    logic [15:0]       mbx_in_data;
    logic              mbx_in_ack = 1'b0;
    logic              mbx_out_we = 1'b0;
    logic [15:0]       mbx_out_wdata = '0;
    logic              mbx_out_full;

    hpi_responder_if hif ();

    hpi_responder #(.MEM_AW(MEM_AW)) dut (
        .Clk          (clk),
        .Reset        (rst),
        .hpi          (hif),
        .loc_addr     (loc_addr),
        .loc_we       (loc_we),
        .loc_wdata    (loc_wdata),
        .loc_rdata    (loc_rdata),
        .mbx_in_valid (mbx_in_valid),
        .mbx_in_data  (mbx_in_data),
        .mbx_in_ack   (mbx_in_ack),
        .mbx_out_we   (mbx_out_we),
        .mbx_out_wdata(mbx_out_wdata),
        .mbx_out_full (mbx_out_full)
    );

    always #5 clk = ~clk;

    // Behavioural model of the responder's architectural state.
    logic [15:0] m_mem [2**MEM_AW];
    logic [15:0] m_ptr = '0;
    logic [15:0] m_dout = '0;
    logic        m_in_valid = 1'b0;
    logic [15:0] m_in_data = '0;
    logic [15:0] m_out_data = '0;
    logic        m_out_full = 1'b0;
    logic        quiet = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    endtask

    // Continuous comparison whenever no transaction is in flight.
    always @(negedge clk) begin
        if (quiet) begin
            check("q_data_out",     hif.hpi_data_out,      m_dout);
            check("q_mbx_in_valid", {15'b0, mbx_in_valid}, {15'b0, m_in_valid});
            check("q_mbx_in_data",  mbx_in_data,           m_in_data);
            check("q_mbx_out_full", {15'b0, mbx_out_full}, {15'b0, m_out_full});
            check("q_loc_rdata",    loc_rdata,             m_mem[loc_addr]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            A_DATA:    return m_mem[m_ptr[MEM_AW:1]];
            A_MAILBOX: return m_out_data;
            A_ADDRESS: return m_ptr;
            default:   return {7'b0, m_in_valid, 7'b0, m_out_full};
        endcase
    endfunction

    task automatic host_write(input logic [1:0] a, input logic [15:0] d, input int side);
        quiet = 1'b0;
        hif.hpi_addr    = a;
        hif.hpi_data_in = d;
        hif.hpi_cs_n    = 1'b0;
        hif.hpi_w_n     = 1'b0;
        cyc(6);
        hif.hpi_cs_n = 1'b1;
        hif.hpi_w_n  = 1'b1;
        cyc(2);
        // The commit lands on the next edge; collide with it here.
        if (side == SIDE_LOC) begin
            loc_addr  = m_ptr[MEM_AW:1];
            loc_wdata = 16'h0F0F;
            loc_we    = 1'b1;
        end
        if (side == SIDE_ACK) mbx_in_ack = 1'b1;
        cyc(1);
        loc_we     = 1'b0;
        mbx_in_ack = 1'b0;
        case (a)
            A_DATA: begin
                m_mem[m_ptr[MEM_AW:1]] = d;
                m_ptr = m_ptr + 16'd2;
            end
            A_MAILBOX: begin
                m_in_data  = d;
                m_in_valid = 1'b1;
            end
            A_ADDRESS: m_ptr = d;
            default: ;
        endcase
        cyc(2);
        quiet = 1'b1;
    endtask

    task automatic host_read(input logic [1:0] a, input int side, input logic [15:0] side_data,
                             output logic [15:0] got);
        logic [15:0] exp;
        int          lat;
        quiet = 1'b0;
        exp = model_read(a);
        lat = (a == A_DATA) ? 4 : 3;
        hif.hpi_addr = a;
        hif.hpi_cs_n = 1'b0;
        hif.hpi_r_n  = 1'b0;
        cyc(lat);
        got = hif.hpi_data_out;
        check("host_read", got, exp);
        cyc(6 - lat);
        hif.hpi_cs_n = 1'b1;
        hif.hpi_r_n  = 1'b1;
        cyc(2);
        if (side == SIDE_MBXOUT) begin
            mbx_out_wdata = side_data;
            mbx_out_we    = 1'b1;
        end
        cyc(1);
        mbx_out_we = 1'b0;
        m_dout = exp;
        if (a == A_DATA) m_ptr = m_ptr + 16'd2;
        if (a == A_MAILBOX) m_out_full = 1'b0;
        if (side == SIDE_MBXOUT) begin
            m_out_data = side_data;
            m_out_full = 1'b1;
        end
        cyc(2);
        quiet = 1'b1;
    endtask

    task automatic loc_write(input logic [MEM_AW-1:0] a, input logic [15:0] d);
        quiet = 1'b0;
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        cyc(1);
        loc_we = 1'b0;
        m_mem[a] = d;
        cyc(2);
        quiet = 1'b1;
    endtask

    task automatic loc_read(input logic [MEM_AW-1:0] a, output logic [15:0] got);
        quiet = 1'b0;
        loc_addr = a;
        cyc(1);
        got = loc_rdata;
        cyc(1);
        quiet = 1'b1;
    endtask

    task automatic mbx_ack();
        quiet = 1'b0;
        mbx_in_ack = 1'b1;
        cyc(1);
        mbx_in_ack = 1'b0;
        m_in_valid = 1'b0;
        cyc(1);
        quiet = 1'b1;
    endtask

    task automatic mbx_load(input logic [15:0] d);
        quiet = 1'b0;
        mbx_out_wdata = d;
        mbx_out_we    = 1'b1;
        cyc(1);
        mbx_out_we = 1'b0;
        m_out_data = d;
        m_out_full = 1'b1;
        cyc(1);
        quiet = 1'b1;
    endtask

    function automatic void model_clear();
        m_ptr      = '0;
        m_dout     = '0;
        m_in_valid = 1'b0;
        m_in_data  = '0;
        m_out_data = '0;
        m_out_full = 1'b0;
    endfunction

    initial begin
        logic [15:0] v;
        logic [15:0] saved;

        hif.hpi_addr    = A_DATA;
        hif.hpi_data_in = '0;
        hif.hpi_cs_n    = 1'b1;
        hif.hpi_r_n     = 1'b1;
        hif.hpi_w_n     = 1'b1;
        hif.hpi_reset_n = 1'b1;
        rst = 1'b1;
        cyc(2);
        check("rst_data_out",     hif.hpi_data_out,      16'h0000);
        check("rst_loc_rdata",    loc_rdata,             16'h0000);
        check("rst_mbx_in_valid", {15'b0, mbx_in_valid}, 16'h0000);
        check("rst_mbx_in_data",  mbx_in_data,           16'h0000);
        check("rst_mbx_out_full", {15'b0, mbx_out_full}, 16'h0000);
        rst = 1'b0;
        cyc(1);

        // Fill the RAM from the local side so every host read has a known answer.
        for (int i = 0; i < 2**MEM_AW; i++) begin
            loc_addr  = i[MEM_AW-1:0];
            loc_wdata = 16'($urandom);
            loc_we    = 1'b1;
            m_mem[i]  = loc_wdata;
            cyc(1);
        end
        loc_we = 1'b0;
        cyc(2);
        quiet = 1'b1;

        host_read(A_STATUS, SIDE_NONE, 16'h0, v);
        check("status_after_reset", v, 16'h0000);

        // Burst write, address readback, local readback, burst read.
        host_write(A_ADDRESS, 16'h0010, SIDE_NONE);
        host_write(A_DATA, 16'h1111, SIDE_NONE);
        host_write(A_DATA, 16'h2222, SIDE_NONE);
        host_write(A_DATA, 16'h3333, SIDE_NONE);
        host_read(A_ADDRESS, SIDE_NONE, 16'h0, v);
        check("burst_ptr", v, 16'h0016);
        loc_read(8'd8,  v); check("loc_word8",  v, 16'h1111);
        loc_read(8'd9,  v); check("loc_word9",  v, 16'h2222);
        loc_read(8'd10, v); check("loc_word10", v, 16'h3333);
        host_write(A_ADDRESS, 16'h0010, SIDE_NONE);
        host_read(A_DATA, SIDE_NONE, 16'h0, v); check("burst_rd0", v, 16'h1111);
        host_read(A_DATA, SIDE_NONE, 16'h0, v); check("burst_rd1", v, 16'h2222);
        host_read(A_DATA, SIDE_NONE, 16'h0, v); check("burst_rd2", v, 16'h3333);

        // Pointer wrap at the top of the 16-bit space.
        host_write(A_ADDRESS, 16'hFFFE, SIDE_NONE);
        host_write(A_DATA, 16'hBEEF, SIDE_NONE);
        host_read(A_ADDRESS, SIDE_NONE, 16'h0, v);
        check("wrap_ptr", v, 16'h0000);
        loc_read(8'd255, v);
        check("wrap_word255", v, 16'hBEEF);

        // Mailboxes in both directions.
        host_write(A_MAILBOX, 16'h00A5, SIDE_NONE);
        check("mbx_in_valid_set", {15'b0, mbx_in_valid}, 16'h0001);
        check("mbx_in_data_set",  mbx_in_data,           16'h00A5);
        host_read(A_STATUS, SIDE_NONE, 16'h0, v); check("status_in_full", v, 16'h0100);
        mbx_ack();
        host_read(A_STATUS, SIDE_NONE, 16'h0, v); check("status_after_ack", v, 16'h0000);
        mbx_load(16'h5A5A);
        host_read(A_STATUS, SIDE_NONE, 16'h0, v); check("status_out_full", v, 16'h0001);
        host_read(A_MAILBOX, SIDE_NONE, 16'h0, v); check("mbx_out_read", v, 16'h5A5A);
        host_read(A_STATUS, SIDE_NONE, 16'h0, v); check("status_out_drained", v, 16'h0000);

        // Same-cycle collisions.
        host_write(A_ADDRESS, 16'h0030, SIDE_NONE);
        host_write(A_DATA, 16'hC0DE, SIDE_LOC);
        loc_read(8'h18, v);
        check("collide_hpi_wins", v, 16'hC0DE);
        host_write(A_MAILBOX, 16'h0077, SIDE_ACK);
        check("collide_write_beats_ack", {15'b0, mbx_in_valid}, 16'h0001);
        mbx_ack();
        mbx_load(16'h1111);
        host_read(A_MAILBOX, SIDE_MBXOUT, 16'h2222, v);
        check("collide_mbx_read_old", v, 16'h1111);
        host_read(A_STATUS, SIDE_NONE, 16'h0, v);
        check("collide_out_stays_full", v, 16'h0001);
        host_read(A_MAILBOX, SIDE_NONE, 16'h0, v);
        check("collide_mbx_new_data", v, 16'h2222);

        // Read and write strobes low together must be ignored.
        saved = m_ptr;
        quiet = 1'b0;
        hif.hpi_addr    = A_DATA;
        hif.hpi_data_in = 16'hDEAD;
        hif.hpi_cs_n = 1'b0;
        hif.hpi_r_n  = 1'b0;
        hif.hpi_w_n  = 1'b0;
        cyc(6);
        hif.hpi_cs_n = 1'b1;
        hif.hpi_r_n  = 1'b1;
        hif.hpi_w_n  = 1'b1;
        cyc(5);
        quiet = 1'b1;
        host_read(A_ADDRESS, SIDE_NONE, 16'h0, v);
        check("both_low_ptr", v, saved);

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int          op;
            logic [1:0]  a;
            quiet    = 1'b0;
            loc_addr = MEM_AW'($urandom);
            op = $urandom_range(0, 5);
            a  = 2'($urandom);
            case (op)
                0:       host_write(a, 16'($urandom), SIDE_NONE);
                1, 2:    host_read(a, SIDE_NONE, 16'h0, v);
                3:       mbx_ack();
                4:       mbx_load(16'($urandom));
                default: loc_write(MEM_AW'($urandom), 16'($urandom));
            endcase
        end

        // System reset in the middle of a DATA write: no commit.
        host_write(A_ADDRESS, 16'h0040, SIDE_NONE);
        saved = m_mem[8'h20];
        quiet = 1'b0;
        hif.hpi_addr    = A_DATA;
        hif.hpi_data_in = ~saved;
        hif.hpi_cs_n = 1'b0;
        hif.hpi_w_n  = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(2);
        hif.hpi_cs_n = 1'b1;
        hif.hpi_w_n  = 1'b1;
        cyc(3);
        rst = 1'b0;
        model_clear();
        cyc(3);
        quiet = 1'b1;
        loc_read(8'h20, v);
        check("reset_no_commit", v, saved);
        host_read(A_ADDRESS, SIDE_NONE, 16'h0, v);
        check("reset_ptr_cleared", v, 16'h0000);

        // HPI soft reset in the middle of a DATA read with ptr=0x0020.
        host_write(A_MAILBOX, 16'h0042, SIDE_NONE);
        mbx_load(16'h9999);
        host_write(A_ADDRESS, 16'h0020, SIDE_NONE);
        saved = m_mem[8'h10];
        quiet = 1'b0;
        hif.hpi_addr = A_DATA;
        hif.hpi_cs_n = 1'b0;
        hif.hpi_r_n  = 1'b0;
        cyc(5);
        hif.hpi_reset_n = 1'b0;
        cyc(4);
        hif.hpi_cs_n = 1'b1;
        hif.hpi_r_n  = 1'b1;
        cyc(3);
        hif.hpi_reset_n = 1'b1;
        model_clear();
        cyc(4);
        quiet = 1'b1;
        check("hpirst_data_out", hif.hpi_data_out, 16'h0000);
        check("hpirst_mbx_in_valid", {15'b0, mbx_in_valid}, 16'h0000);
        check("hpirst_mbx_out_full", {15'b0, mbx_out_full}, 16'h0000);
        host_read(A_ADDRESS, SIDE_NONE, 16'h0, v);
        check("hpirst_ptr", v, 16'h0000);
        loc_read(8'h10, v);
        check("hpirst_ram_kept", v, saved);
        host_read(A_MAILBOX, SIDE_NONE, 16'h0, v);
        check("hpirst_mbx_out_cleared", v, 16'h0000);

        quiet = 1'b0;
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
